// File: rtl/fifo_sync_pkg.sv
// rtl/fifo_sync_pkg.sv - shared constants, state encoding and helpers for the sync FIFO slice
package fifo_sync_pkg;

  localparam int FIFO_ABITS = 10;
  localparam int FIFO_DBITS = 16;
  localparam int FIFO_FTHRD = 800;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_sync_wr_arb.sv
// rtl/fifo_sync_wr_arb.sv - round-robin burst arbiter sharing one sync FIFO write port
module fifo_sync_wr_arb
  import fifo_sync_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DBITS = FIFO_DBITS,
  parameter int ABITS = FIFO_ABITS,
  parameter int FTHRD = FIFO_FTHRD,
  parameter int BURST = 8,
  localparam int GW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DBITS-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_wren,
  output logic [DBITS-1:0]      fifo_wr_data,
  input  logic                  fifo_wrfull,
  input  logic [ABITS-1:0]      fifo_num,
  output logic [GW-1:0]         grant_id,
  output logic                  grant_act
);

  localparam int CW = clog2(BURST + 1);

  arb_state_t              state, state_nxt;
  logic [GW-1:0]           rr_ptr;
  logic [CW-1:0]           beat_cnt;
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic signed [ABITS+1:0] headroom;
  logic                    headroom_ok;
  logic                    grant_rdy;
  logic                    hs;
  logic                    xfer_exit;
  logic [DBITS-1:0]        cur_data;

  rr_pick #(.NREQ(NREQ), .IW(GW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The in-flight registered write is not yet reflected in fifo_num, so count it here.
  assign headroom    = (ABITS+2)'(FTHRD) - {2'b00, fifo_num} - {{(ABITS+1){1'b0}}, fifo_wren};
  assign headroom_ok = (headroom >= $signed((ABITS+2)'(BURST)));
  assign cur_data    = req_data[int'(grant_id)*DBITS +: DBITS];

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant_act = 1'b0;
    grant_rdy = 1'b0;
    hs        = 1'b0;
    xfer_exit = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && headroom_ok) state_nxt = XFER;
      end
      XFER: begin
        grant_act           = 1'b1;
        grant_rdy           = (beat_cnt < CW'(BURST)) & ~fifo_wrfull;
        req_ready[grant_id] = grant_rdy;
        hs                  = req_valid[grant_id] & grant_rdy;
        xfer_exit           = (hs && (beat_cnt == CW'(BURST - 1))) || !req_valid[grant_id];
        if (xfer_exit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      grant_id     <= '0;
      fifo_wren    <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wren <= hs;
      if (hs) begin
        fifo_wr_data <= cur_data;
        beat_cnt     <= beat_cnt + CW'(1);
      end
      if (state == IDLE && state_nxt == XFER) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end
      if (xfer_exit) rr_ptr <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_sync_wr_arb.sv
// tb/tb_fifo_sync_wr_arb.sv - directed table and sequence bench for fifo_sync_wr_arb
module tb_fifo_sync_wr_arb;

  localparam int NREQ  = 4;
  localparam int DBITS = 16;
  localparam int ABITS = 10;
  localparam int FTHRD = 800;
  localparam int BURST = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DBITS-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wren;
  logic [DBITS-1:0]      fifo_wr_data;
  logic                  fifo_wrfull;
  logic [ABITS-1:0]      fifo_num;
  logic [1:0]            grant_id;
  logic                  grant_act;

  fifo_sync_wr_arb #(
    .NREQ(NREQ), .DBITS(DBITS), .ABITS(ABITS), .FTHRD(FTHRD), .BURST(BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wren    (fifo_wren),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wrfull  (fifo_wrfull),
    .fifo_num     (fifo_num),
    .grant_id     (grant_id),
    .grant_act    (grant_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    int         num;
    bit         act;
    int         id;
  } vec_t;

  vec_t        tbl[8];
  int          errors = 0;
  int          checks = 0;
  int          rem[NREQ];
  logic [15:0] nxt[NREQ];
  int          exp_q[$];
  int          grant_q[$];
  int          len_q[$];
  int          wr_cnt;
  int          cur_len;
  int          max_num;
  bit          prev_act;
  bit          prev_hs;
  bit          fifo_model;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_seq(input string name, input int q[$], input int exp[$]);
    chk({name, "_count"}, int'(q.size() >= exp.size()), 1);
    for (int k = 0; k < exp.size(); k++)
      if (k < q.size()) chk(name, q[k], exp[k]);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = (rem[i] > 0);
      req_data[i*DBITS +: DBITS] = nxt[i];
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    grant_q.delete();
    len_q.delete();
    wr_cnt   = 0;
    cur_len  = 0;
    prev_act = 1'b0;
    prev_hs  = 1'b0;
  endtask

  // One clock: sample at negedge, check the registered write against the previous accept, then update producers.
  task automatic step();
    logic [NREQ-1:0] hs;
    logic            wr_seen;
    @(negedge clk);
    hs      = req_valid & req_ready;
    wr_seen = fifo_wren;
    if (!rst) begin
      chk("wren_latency", int'(fifo_wren), int'(prev_hs));
      if (fifo_wren) begin
        wr_cnt++;
        if (exp_q.size() > 0) chk("wr_data", int'(fifo_wr_data), exp_q.pop_front());
        else chk("wr_unexpected", 1, 0);
      end
      if (fifo_model) chk("no_write_when_full", int'(fifo_wren & fifo_wrfull), 0);
      if (grant_act && !prev_act) begin
        grant_q.push_back(int'(grant_id));
        cur_len = 0;
      end
      if (!grant_act && prev_act) len_q.push_back(cur_len);
      prev_act = grant_act;
    end
    prev_hs = 1'b0;
    if (!rst)
      for (int i = 0; i < NREQ; i++)
        if (hs[i]) begin
          exp_q.push_back(int'(nxt[i]));
          prev_hs = 1'b1;
          cur_len++;
        end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs[i]) begin
        rem[i]--;
        nxt[i]++;
      end
    if (fifo_model) begin
      if (wr_seen) fifo_num = fifo_num + 10'd1;
      fifo_wrfull = (int'(fifo_num) >= FTHRD);
      if (int'(fifo_num) > max_num) max_num = int'(fifo_num);
    end
    drive();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    fifo_model  = 1'b0;
    fifo_num    = '0;
    fifo_wrfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      nxt[i] = 16'(i * 16'h1000);
    end
    drive();
    step();
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    int e[$];
    bool_loop: begin end
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    fifo_wrfull = 1'b0;
    fifo_num = '0;
    max_num = 0;
    clear_model();

    tbl[0] = '{4'b0001, 0,   1'b1, 0};
    tbl[1] = '{4'b0100, 0,   1'b1, 2};
    tbl[2] = '{4'b1000, 10,  1'b1, 3};
    tbl[3] = '{4'b0000, 0,   1'b0, 0};
    tbl[4] = '{4'b0110, 792, 1'b1, 1};
    tbl[5] = '{4'b0001, 793, 1'b0, 0};
    tbl[6] = '{4'b1111, 800, 1'b0, 0};
    tbl[7] = '{4'b1010, 100, 1'b1, 1};

    do_reset();
    chk("rst_wren", int'(fifo_wren), 0);
    chk("rst_wr_data", int'(fifo_wr_data), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_grant_act", int'(grant_act), 0);

    for (int k = 0; k < 8; k++) begin
      do_reset();
      fifo_num = 10'(tbl[k].num);
      for (int i = 0; i < NREQ; i++) rem[i] = tbl[k].valid[i] ? 4 : 0;
      drive();
      #1;
      chk("tbl_idle_ready", int'(req_ready), 0);
      step();
      chk("tbl_act", int'(grant_act), int'(tbl[k].act));
      chk("tbl_id", int'(grant_id), tbl[k].id);
      chk("tbl_ready", int'(req_ready), tbl[k].act ? (1 << tbl[k].id) : 0);
    end

    // Single requester, 20 beats: bursts of 8, 8, 4.
    do_reset();
    rem[0] = 20;
    nxt[0] = 16'h0001;
    drive();
    repeat (40) step();
    chk("t1_writes", wr_cnt, 20);
    chk("t1_ngrants", grant_q.size(), 3);
    e = '{0, 0, 0};
    chk_seq("t1_grant", grant_q, e);
    e = '{8, 8, 4};
    chk_seq("t1_len", len_q, e);

    // All four requesters continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 1000;
    drive();
    repeat (80) step();
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("t2_order", grant_q, e);
    e = '{8, 8, 8, 8, 8, 8, 8, 8};
    chk_seq("t2_len", len_q, e);

    // Headroom boundary: 793 blocks, 792 grants.
    do_reset();
    fifo_num = 10'd793;
    for (int i = 0; i < NREQ; i++) rem[i] = 5;
    drive();
    repeat (4) begin
      step();
      chk("t3_blocked_act", int'(grant_act), 0);
      chk("t3_blocked_ready", int'(req_ready), 0);
    end
    fifo_num = 10'd792;
    step();
    chk("t3_grant_act", int'(grant_act), 1);
    chk("t3_grant_id", int'(grant_id), 0);

    // Early termination after 3 beats; pointer moves to 3.
    do_reset();
    rem[2] = 3;
    drive();
    step();
    step();
    rem[0] = 2;
    rem[3] = 2;
    drive();
    repeat (25) step();
    e = '{2, 3, 0};
    chk_seq("t4_order", grant_q, e);
    e = '{3, 2, 2};
    chk_seq("t4_len", len_q, e);
    chk("t4_writes", wr_cnt, 7);

    // Reset mid-burst at beat 4 of requester 3, with rr_ptr previously at 2.
    do_reset();
    rem[1] = 2;
    drive();
    repeat (6) step();
    rem[3] = 20;
    drive();
    begin
      bit reached;
      reached = 1'b0;
      for (int c = 0; c < 20 && !reached; c++) begin
        step();
        if (grant_act && grant_id == 2'd3 && cur_len == 3) reached = 1'b1;
      end
      chk("t6_reach_beat3", int'(reached), 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_wren", int'(fifo_wren), 0);
    chk("t6_ready", int'(req_ready), 0);
    chk("t6_act", int'(grant_act), 0);
    chk("t6_grant_id", int'(grant_id), 0);
    clear_model();
    rem[0] = 5;
    drive();
    step();
    chk("t6_restart_act", int'(grant_act), 1);
    chk("t6_restart_id", int'(grant_id), 0);

    // Flood a modelled FIFO with no reads.
    do_reset();
    fifo_model = 1'b1;
    max_num = 0;
    for (int i = 0; i < NREQ; i++) rem[i] = 100000;
    drive();
    repeat (1100) step();
    chk("t5_final_num", int'(fifo_num), FTHRD);
    chk("t5_full", int'(fifo_wrfull), 1);
    chk("t5_max_num", int'(max_num <= FTHRD), 1);
    chk("t5_writes", wr_cnt, FTHRD);
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("t5_order", grant_q, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_wr_arb.md
Name: fifo_sync_wr_arb

Overview:
Round-robin write arbiter that shares one synchronous FIFO (bfm_fifo_sync-style write port: wren/wr_data, wrfull, fifo_num) between NREQ producers.
- Grants one requester at a time for a burst of up to BURST beats, only when the FIFO has guaranteed headroom, so no write is ever presented while full.
- Registers the FIFO write port. Sits directly in front of the FIFO's write side.

Parameters:
NREQ, 4, number of requesters (2..16)
DBITS, 16, data width; must equal the FIFO's DBITS
ABITS, 10, FIFO address / fifo_num width; must equal the FIFO's ABITS
FTHRD, 800, FIFO full threshold; must equal the FIFO's FTHRD
BURST, 8, maximum beats per grant (1..FTHRD-2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester data valid
req_data  in  NREQ*DBITS  requester i occupies bits [i*DBITS +: DBITS]
req_ready  out  NREQ  per-requester accept; a beat transfers when valid&ready
fifo_wren  out  1  FIFO write enable, registered
fifo_wr_data  out  DBITS  FIFO write data, registered
fifo_wrfull  in  1  FIFO full flag
fifo_num  in  ABITS  FIFO occupancy
grant_id  out  clog2(NREQ) (min 1)  index of current/last granted requester
grant_act  out  1  high while in XFER

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high.
- Reset values:
  - fifo_wren=0, fifo_wr_data=0, req_ready=0, grant_id=0, grant_act=0.
  - Internal: rr_ptr=0, beat_cnt=0, state=IDLE.
  - A rst asserted mid-burst aborts the burst at the same edge. A beat accepted in the reset cycle is not written.
- FSM has two states, IDLE and XFER.
- IDLE:
  - req_ready is all 0.
  - headroom_ok = (FTHRD - fifo_num - fifo_wren) >= BURST, computed in ABITS+2 bits signed. The fifo_wren term covers the one in-flight registered write.
  - If any req_valid is set and headroom_ok: select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ. Register it to grant_id, clear beat_cnt, go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - req_ready[grant_id] = (beat_cnt < BURST) & ~fifo_wrfull. This is combinational; every other ready bit is 0.
  - On handshake: fifo_wren<=1, fifo_wr_data<=req_data[grant_id], beat_cnt+1. Latency from accept to FIFO write is 1 cycle.
  - With no handshake: fifo_wren<=0.
  - Exit to IDLE when the handshake makes beat_cnt==BURST, or when req_valid[grant_id]==0 (requester done or idle).
  - On exit: rr_ptr <= (grant_id+1) mod NREQ, with explicit wrap when NREQ is not a power of 2.
- Arbitration bubble: one IDLE cycle always separates consecutive bursts, including back-to-back bursts from the same requester.
- Fairness: a continuously valid requester waits at most NREQ-1 bursts.
- Overflow guarantee: with headroom checked at grant time, fifo_wren is never asserted while the FIFO's wrfull is 1. The fifo_wrfull gating is a secondary safety net.
- Reads are independent: reads drain the FIFO concurrently, and a read that lowers fifo_num mid-burst has no effect until the next IDLE evaluation.
- Boundary case: if fifo_num == FTHRD-BURST, a grant is allowed. If fifo_num == FTHRD-BURST+1, no grant until occupancy drops.

Decomposition:
- Shared package fifo_sync_pkg holds:
  - constants for the FIFO's ABITS/DBITS/FTHRD defaults;
  - the state encoding localparams IDLE=0, XFER=1;
  - a clog2 function.
- One natural sub-module, rr_pick: a combinational round-robin priority picker that takes NREQ request bits plus rr_ptr and returns a found flag and an index. It is reused by later read-side schedulers.

Test Plan:
- Single requester, empty FIFO: req0 valid with 20 beats (0x0001..0x0014), BURST=8. Required: grants of 8, 8, 4 beats with a 1-cycle IDLE between them; fifo_wren trails each accept by 1 cycle; data is in order; grant_id=0 throughout.
- All 4 requesters continuously valid. Required: grant order is 0,1,2,3,0,...; each grant is 8 beats; no requester is starved.
- Headroom boundary, FTHRD=800, BURST=8: fifo_num held at 792 gives a grant. fifo_num held at 793 gives no grant, grant_act=0 and req_ready=0, until fifo_num drops to 792.
- Early termination: req2 drops valid after 3 beats. Required: exactly 3 writes, return to IDLE, rr_ptr=3; the next grant goes to req3 if it is valid.
- Connected to the real FIFO with no reads and 4 requesters flooding. Required: the FIFO fills without any fifo_wren while wrfull=1, and fifo_num never exceeds FTHRD.
- Synchronous rst pulsed for 1 cycle mid-burst (beat 4). Required: the next cycle shows fifo_wren=0, req_ready=0, grant_act=0; after release, arbitration restarts from requester 0.
